// File: rtl/alu_seq_if.sv
// alu_seq bus: operand/opcode handshake toward the ALU and the registered
// result/flag return path. The master drives operations, the slave is the ALU.
interface alu_seq_if #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [SHW-1:0]   d;
   logic [WIDTH-1:0] alu_in_a;
   logic [WIDTH-1:0] alu_in_b;
   logic             out_valid;
   logic [WIDTH-1:0] alu_out;
   logic             S;
   logic             Z;
   logic             C;
   logic             V;

   modport master (
      output in_valid, opcode, d, alu_in_a, alu_in_b,
      input  in_ready, out_valid, alu_out, S, Z, C, V
   );

   modport slave (
      input  in_valid, opcode, d, alu_in_a, alu_in_b,
      output in_ready, out_valid, alu_out, S, Z, C, V
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with carry/overflow flags, add-with-carry and an
// iterative shift-add multiplier. Single-cycle ops complete one edge after
// acceptance; mul occupies the block for WIDTH shift-add steps.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic        clk,
   input logic        rst,
   alu_seq_if.slave   bus
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_ADC  = 4'b0101;
   localparam logic [3:0] OP_MOV  = 4'b0110;
   localparam logic [3:0] OP_ZERO = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_ROL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;

   localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [SHW-1:0]     cnt;

   logic [WIDTH-1:0]   res;
   logic               c_n;
   logic               v_n;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH:0]     sh_ext;
   logic [SHW:0]       rot_back;
   logic [2*WIDTH-1:0] acc_step;

   assign bus.in_ready = (state == IDLE) && !rst;

   assign acc_step = acc + (mplier[0] ? mcand : '0);

   // Single-cycle datapath: result plus carry/overflow for the presented opcode.
   always_comb begin
      res      = '0;
      c_n      = 1'b0;
      v_n      = 1'b0;
      sum_ext  = '0;
      sh_ext   = '0;
      rot_back = '0;
      case (bus.opcode)
         OP_ADD, OP_ADC: begin
            sum_ext = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b}
                      + {{WIDTH{1'b0}}, (bus.opcode == OP_ADC) & bus.C};
            res = sum_ext[WIDTH-1:0];
            c_n = sum_ext[WIDTH];
            v_n = (bus.alu_in_a[WIDTH-1] == bus.alu_in_b[WIDTH-1]) &&
                  (res[WIDTH-1] != bus.alu_in_a[WIDTH-1]);
         end
         OP_SUB: begin
            sum_ext = {1'b0, bus.alu_in_a} + {1'b0, ~bus.alu_in_b}
                      + {{WIDTH{1'b0}}, 1'b1};
            res = sum_ext[WIDTH-1:0];
            c_n = sum_ext[WIDTH];
            v_n = (bus.alu_in_a[WIDTH-1] != bus.alu_in_b[WIDTH-1]) &&
                  (res[WIDTH-1] != bus.alu_in_a[WIDTH-1]);
         end
         OP_AND:  res = bus.alu_in_a & bus.alu_in_b;
         OP_OR:   res = bus.alu_in_a | bus.alu_in_b;
         OP_XOR:  res = bus.alu_in_a ^ bus.alu_in_b;
         OP_MOV:  res = bus.alu_in_b;
         OP_ZERO: res = '0;
         OP_SLL: begin
            sh_ext = {1'b0, bus.alu_in_a} << bus.d;
            res    = sh_ext[WIDTH-1:0];
            c_n    = sh_ext[WIDTH];
         end
         OP_ROL: begin
            rot_back = (SHW+1)'(WIDTH) - {1'b0, bus.d};
            res      = (bus.alu_in_a << bus.d) | (bus.alu_in_a >> rot_back);
            c_n      = res[0];
         end
         OP_SRL: begin
            sh_ext = {bus.alu_in_a, 1'b0} >> bus.d;
            res    = sh_ext[WIDTH:1];
            c_n    = sh_ext[0];
         end
         OP_SRA: begin
            sh_ext = $signed({bus.alu_in_a, 1'b0}) >>> bus.d;
            res    = sh_ext[WIDTH:1];
            c_n    = sh_ext[0];
         end
         OP_MUL: res = '0;
         default: v_n = 1'b1;
      endcase
   end

   // Control FSM: registers single-cycle results in IDLE, runs shift-add steps in MUL.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
         bus.alu_out   <= '0;
         bus.S         <= 1'b0;
         bus.Z         <= 1'b0;
         bus.C         <= 1'b0;
         bus.V         <= 1'b0;
         mcand         <= '0;
         mplier        <= '0;
         acc           <= '0;
         cnt           <= '0;
      end else begin
         bus.out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (bus.opcode == OP_MUL) begin
                     mcand  <= {{WIDTH{1'b0}}, bus.alu_in_a};
                     mplier <= bus.alu_in_b;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= MUL;
                  end else begin
                     bus.alu_out   <= res;
                     bus.S         <= res[WIDTH-1];
                     bus.Z         <= (res == '0);
                     bus.C         <= c_n;
                     bus.V         <= v_n;
                     bus.out_valid <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + SHW'(1);
               if (cnt == LAST_STEP) begin
                  bus.alu_out   <= acc_step[WIDTH-1:0];
                  bus.S         <= acc_step[WIDTH-1];
                  bus.Z         <= (acc_step[WIDTH-1:0] == '0);
                  bus.C         <= |acc_step[2*WIDTH-1:WIDTH];
                  bus.V         <= |acc_step[2*WIDTH-1:WIDTH];
                  bus.out_valid <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an
// arithmetic reference model of the opcode rules.
module tb_alu_seq;

   localparam int W = 16;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_ROL = 4'h9;
   localparam logic [3:0] OP_SRL = 4'hA;
   localparam logic [3:0] OP_SRA = 4'hB;
   localparam logic [3:0] OP_MUL = 4'hC;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   bit   model_c  = 1'b0;

   logic [15:0] last_r;
   bit          last_s, last_z, last_c, last_v;

   logic [3:0]  b_op [8];
   logic [15:0] b_a  [8];
   logic [15:0] b_b  [8];
   logic [3:0]  b_d  [8];

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Watchdog so a stuck handshake still ends the run.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: plain integer arithmetic on the opcode rules.
   function automatic void refModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] d, input bit cin,
                                    output logic [15:0] r, output bit c, output bit v);
      longint ua, ub, sa, sb, full;
      int     dd;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dd = int'(d);
      c  = 1'b0;
      v  = 1'b0;
      r  = 16'h0;
      case (op)
         4'h0: begin
            full = ua + ub;
            r = 16'(full);
            c = full > 65535;
            v = (sa + sb > 32767) || (sa + sb < -32768);
         end
         4'h1: begin
            full = ua - ub;
            r = 16'(full);
            c = ua >= ub;
            v = (sa - sb > 32767) || (sa - sb < -32768);
         end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: begin
            full = ua + ub + longint'(cin);
            r = 16'(full);
            c = full > 65535;
            v = (sa + sb + longint'(cin) > 32767) || (sa + sb + longint'(cin) < -32768);
         end
         4'h6: r = b;
         4'h7: r = 16'h0;
         4'h8: begin
            r = 16'(ua << dd);
            c = (dd != 0) && (((ua >> (16 - dd)) & 1) != 0);
         end
         4'h9: begin
            r = 16'((ua << dd) | (ua >> (16 - dd)));
            c = r[0];
         end
         4'hA: begin
            r = 16'(ua >> dd);
            c = (dd != 0) && (((ua >> (dd - 1)) & 1) != 0);
         end
         4'hB: begin
            r = 16'(sa >>> dd);
            c = (dd != 0) && (((sa >>> (dd - 1)) & 1) != 0);
         end
         4'hC: begin
            full = ua * ub;
            r = 16'(full);
            c = (full >> 16) != 0;
            v = c;
         end
         default: v = 1'b1;
      endcase
   endfunction

   // One comparison: counted, and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present an operation with in_valid high.
   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] d);
      bus.opcode   = op;
      bus.alu_in_a = a;
      bus.alu_in_b = b;
      bus.d        = d;
      bus.in_valid = 1'b1;
   endtask

   // Compare the registered result and all flags with the model, then advance the model carry.
   task automatic checkResult(input string tag, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [3:0] d);
      logic [15:0] er;
      bit          ec, ev;
      refModel(op, a, b, d, model_c, er, ec, ev);
      checkOutput({tag, "_out"}, 32'(bus.alu_out), 32'(er));
      checkOutput({tag, "_S"},   32'(bus.S),       32'(er[15]));
      checkOutput({tag, "_Z"},   32'(bus.Z),       32'(er == 16'h0));
      checkOutput({tag, "_C"},   32'(bus.C),       32'(ec));
      checkOutput({tag, "_V"},   32'(bus.V),       32'(ev));
      last_r  = bus.alu_out;
      last_s  = bus.S;
      last_z  = bus.Z;
      last_c  = bus.C;
      last_v  = bus.V;
      model_c = ec;
   endtask

   // Isolated operation: accept, measure the out_valid delay, check, confirm a single pulse.
   task automatic runOp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d);
      int seen;
      string tag;
      seen = 0;
      tag  = $sformatf("op%0h", op);
      applyStimulus(op, a, b, d);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int i = 1; i <= W + 3; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            seen = i;
            break;
         end
      end
      checkOutput({tag, "_latency"}, 32'(seen), (op == OP_MUL) ? 32'(W + 1) : 32'd1);
      if (seen != 0) checkResult(tag, op, a, b, d);
      @(negedge clk);
      checkOutput({tag, "_single_pulse"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Back-to-back single-cycle ops with in_valid held high across the burst.
   task automatic runBurst(input int n);
      applyStimulus(b_op[0], b_a[0], b_b[0], b_d[0]);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (i + 1 < n) applyStimulus(b_op[i+1], b_a[i+1], b_b[i+1], b_d[i+1]);
         else bus.in_valid = 1'b0;
         @(negedge clk);
         checkOutput($sformatf("burst%0d_valid", i), 32'(bus.out_valid), 32'd1);
         checkResult($sformatf("burst%0d", i), b_op[i], b_a[i], b_b[i], b_d[i]);
      end
      @(negedge clk);
      checkOutput("burst_end_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Multiply while upstream keeps in_valid high with different operands during the busy window.
   task automatic doMul(input logic [15:0] a, input logic [15:0] b);
      applyStimulus(OP_MUL, a, b, 4'h0);
      @(posedge clk);
      #1;
      bus.opcode   = OP_ADD;
      bus.alu_in_a = 16'h1111;
      bus.alu_in_b = 16'h2222;
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         if (i >= 2) checkOutput("mul_busy_ready", 32'(bus.in_ready), 32'd0);
         checkOutput("mul_no_early_valid", 32'(bus.out_valid), 32'd0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("mul_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("mul_ready_back", 32'(bus.in_ready), 32'd1);
      checkResult("mul", OP_MUL, a, b, 4'h0);
      @(negedge clk);
      checkOutput("mul_single_pulse", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Directed sequence followed by randomized operations.
   initial begin
      int          nvalid;
      logic [15:0] ra, rb;
      logic [3:0]  rop, rd;

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.opcode   = 4'h0;
      bus.alu_in_a = 16'h0;
      bus.alu_in_b = 16'h0;
      bus.d        = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out", 32'(bus.alu_out), 32'd0);
      checkOutput("rst_flags", 32'({bus.S, bus.Z, bus.C, bus.V}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_rst", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      $display("[TB] directed arithmetic");
      runOp(OP_ADD, 16'h7FFF, 16'h0001, 4'h0);
      checkOutput("add_ovf_out", 32'(last_r), 32'h8000);
      checkOutput("add_ovf_flags", 32'({last_s, last_z, last_c, last_v}), 32'b1001);
      runOp(OP_SUB, 16'h0003, 16'h0005, 4'h0);
      checkOutput("sub_borrow_out", 32'(last_r), 32'hFFFE);
      checkOutput("sub_borrow_flags", 32'({last_s, last_c, last_v}), 32'b100);
      runOp(OP_SUB, 16'h0005, 16'h0005, 4'h0);
      checkOutput("sub_eq_out", 32'(last_r), 32'h0000);
      checkOutput("sub_eq_flags", 32'({last_z, last_c}), 32'b11);

      b_op[0] = OP_ADD; b_a[0] = 16'hFFFF; b_b[0] = 16'h0001; b_d[0] = 4'h0;
      b_op[1] = OP_ADC; b_a[1] = 16'h0000; b_b[1] = 16'h0000; b_d[1] = 4'h0;
      runBurst(2);
      checkOutput("adc_chain_out", 32'(last_r), 32'h0001);
      checkOutput("adc_chain_flags", 32'({last_z, last_c}), 32'b00);

      $display("[TB] directed shifts and illegal opcode");
      runOp(OP_SRA, 16'h8001, 16'h0000, 4'd1);
      checkOutput("sra_out", 32'(last_r), 32'hC000);
      checkOutput("sra_C", 32'(last_c), 32'd1);
      runOp(OP_ROL, 16'h8001, 16'h0000, 4'd4);
      checkOutput("rol_out", 32'(last_r), 32'h0018);
      checkOutput("rol_C", 32'(last_c), 32'd0);
      runOp(OP_SRL, 16'h1234, 16'h0000, 4'd0);
      checkOutput("srl0_out", 32'(last_r), 32'h1234);
      checkOutput("srl0_C", 32'(last_c), 32'd0);
      runOp(4'hE, 16'h1234, 16'h5678, 4'd3);
      checkOutput("illegal_out", 32'(last_r), 32'h0000);
      checkOutput("illegal_flags", 32'({last_s, last_z, last_c, last_v}), 32'b0101);

      $display("[TB] directed multiply");
      doMul(16'h00FF, 16'h0003);
      checkOutput("mul_small_out", 32'(last_r), 32'h02FD);
      checkOutput("mul_small_CV", 32'({last_c, last_v}), 32'b00);
      doMul(16'h0100, 16'h0100);
      checkOutput("mul_wrap_out", 32'(last_r), 32'h0000);
      checkOutput("mul_wrap_flags", 32'({last_z, last_c, last_v}), 32'b111);

      $display("[TB] reset during multiply");
      applyStimulus(OP_MUL, 16'h1234, 16'h0FF3, 4'h0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_ready_in_rst", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("abort_out", 32'(bus.alu_out), 32'd0);
      checkOutput("abort_flags", 32'({bus.S, bus.Z, bus.C, bus.V}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_c = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready_after", 32'(bus.in_ready), 32'd1);
      nvalid = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) nvalid++;
      end
      checkOutput("abort_no_valid", 32'(nvalid), 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] eight back-to-back adds");
      for (int i = 0; i < 8; i++) begin
         b_op[i] = OP_ADD;
         b_a[i]  = 16'($urandom);
         b_b[i]  = 16'($urandom);
         b_d[i]  = 4'h0;
      end
      runBurst(8);

      $display("[TB] randomized operations");
      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rd  = 4'($urandom_range(0, 15));
         runOp(rop, ra, rb, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
